// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for the memory wait window; o_tc flags the last allowed cycle (TIMEOUT-1).
// Clear has priority over enable; the count saturates at terminal count.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16,
    localparam int W      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!Reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the word at pc over a valid/ready memory handshake and holds it for decode; REQ->WAIT->OUT, 2 cycles minimum.
// PCWre pulses only when decode accepts, so the PC stalls on slow memory or decode back-pressure.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] pc,
    output logic        PCWre,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        id_ready,
    output logic        fetch_err
);

    fetch_state_t r_state;
    fetch_state_t w_next;

    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_fetch_err;

    logic        w_misaligned;
    logic        w_tc;
    logic        w_capture;
    logic [31:0] w_capture_dat;
    logic        w_capture_err;
    logic        w_release;

    assign w_misaligned = (pc[1:0] != 2'b00);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .Reset(Reset),
        .i_clr(r_state == REQ),
        .i_en (r_state == WAIT),
        .o_tc (w_tc)
    );

    // Reset gates the decoded strobes immediately, so nothing leaks out mid-WAIT or mid-OUT.
    assign PCWre    = Reset && (r_state == OUT) && id_ready;
    assign mem_req  = Reset && (r_state == REQ) && !w_misaligned;
    assign mem_addr = (Reset && (r_state == REQ)) ? (pc & WORD_ALIGN_MASK) : 32'h0;

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;

    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_capture_dat = NOP_INSTR;
        w_capture_err = 1'b1;
        w_release     = 1'b0;
        case (r_state)
            IDLE: w_next = REQ;
            REQ: begin
                if (w_misaligned) begin
                    w_next    = OUT;
                    w_capture = 1'b1;
                end else if (mem_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                // A response on the threshold cycle beats the timeout.
                if (mem_rvalid) begin
                    w_next        = OUT;
                    w_capture     = 1'b1;
                    w_capture_dat = mem_rdata;
                    w_capture_err = 1'b0;
                end else if (w_tc) begin
                    w_next    = OUT;
                    w_capture = 1'b1;
                end
            end
            OUT: begin
                if (id_ready) begin
                    w_next    = REQ;
                    w_release = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else if (w_capture) begin
            r_instr       <= w_capture_dat;
            r_instr_valid <= 1'b1;
            r_fetch_err   <= w_capture_err;
        end else if (w_release) begin
            r_instr_valid <= 1'b0;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter interface in the single-cycle CPU.
- Takes `pc` from the PC register, fetches the word at that address from instruction memory over a valid/ready request/response handshake, and presents it to decode.
- Owns `PCWre`: it advances the PC only after decode has accepted the current instruction. The PC therefore stalls on slow memory or on decode back-pressure.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT before the fetch is aborted; must be ≥ 2.
- NOP_INSTR, 32'h0000_0000: word substituted for `instr` on any fetch error.

Ports:
- clk  in  1: rising-edge clock.
- Reset  in  1: synchronous, active-low reset.
- pc  in  32: current PC from the PC register.
- PCWre  out  1: PC write enable to the PC register; the PC loads its next value at the clk edge ending a cycle where PCWre=1.
- mem_req  out  1: request valid to instruction memory.
- mem_addr  out  32: word-aligned request address.
- mem_ready  in  1: memory accepts the request this cycle.
- mem_rvalid  in  1: response data valid.
- mem_rdata  in  32: response data.
- instr  out  32: fetched instruction to decode.
- instr_valid  out  1: `instr` is valid.
- id_ready  in  1: decode consumes `instr` this cycle.
- fetch_err  out  1: current `instr` results from a misaligned PC or a timeout.

Behaviour:
- States: IDLE, REQ, WAIT, OUT. All outputs are registered except PCWre, mem_req and mem_addr, which are decoded from the state.
- Reset=0 at a clk edge puts the block in IDLE with instr=0, instr_valid=0, fetch_err=0, wait counter=0. It also forces PCWre=0 and mem_req=0, and this applies even mid-WAIT or mid-OUT.
- IDLE: all outputs inactive. Next state is REQ unconditionally (one-cycle gap after reset release).
- REQ: mem_req=1, mem_addr={pc[31:2],2'b00}.
  - If pc[1:0]≠0: mem_req is forced to 0; at the edge, instr←NOP_INSTR, fetch_err←1, instr_valid←1, go to OUT.
  - Else if mem_ready=1: go to WAIT and clear the counter.
  - Else stay in REQ, holding mem_addr stable.
- WAIT: mem_req=0.
  - mem_rvalid=1: instr←mem_rdata, fetch_err←0, instr_valid←1, go to OUT.
  - Else the counter increments. When the counter reaches TIMEOUT-1 with no rvalid: instr←NOP_INSTR, fetch_err←1, instr_valid←1, go to OUT.
  - A response arriving in the same cycle as the timeout threshold wins: data is taken and fetch_err=0.
- OUT: instr_valid=1 and instr is held stable.
  - id_ready=1: PCWre=1 for that cycle only; at the edge instr_valid←0 and go to REQ.
  - id_ready=0: PCWre=0 and stay in OUT.
- mem_rvalid is ignored in IDLE, REQ and OUT. At most one request is outstanding.
- The memory shares Reset, so no stale responses cross a reset.
- Latency for a single-cycle-ready memory with rvalid one cycle after accept: REQ → WAIT → OUT. instr_valid rises 2 cycles after REQ entry. Throughput is one instruction per 3 cycles when id_ready is held high.
- PCWre is never high in IDLE, REQ or WAIT, so the PC holds while any fetch is in progress.
- pc is sampled only in REQ. It must not change outside PCWre, which holds because this block is the sole driver of PCWre.

Decomposition:
- Shared package `fetch_pkg`:
  - state encoding enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3);
  - NOP_INSTR default;
  - WORD_ALIGN_MASK=32'hFFFF_FFFC.
- One natural sub-module, `fetch_timeout_ctr`: clear/enable inputs, terminal-count output at TIMEOUT-1, width $clog2(TIMEOUT).
- The FSM and output registers stay in the top module.

Test Plan:
- Reset=0 for 3 cycles, then 1 → while low, all outputs 0. The first cycle after release is IDLE; the next cycle shows mem_req=1 with mem_addr=pc.
- pc=32'h0000_0040, mem_ready=1, rvalid one cycle later with rdata=32'h2008_0005, id_ready=1 → instr_valid=1 with instr=32'h2008_0005 and fetch_err=0. PCWre=1 for exactly one cycle. The next REQ shows the new pc.
- Same fetch with id_ready=0 for 4 cycles → instr, instr_valid and fetch_err held, PCWre=0 throughout. Raising id_ready gives a single PCWre pulse.
- pc=32'h0000_0042 → mem_req stays 0. Next cycle: instr=NOP_INSTR, fetch_err=1, instr_valid=1.
- mem_ready=1 but rvalid never asserted, TIMEOUT=16 → exactly 16 cycles after entering WAIT: instr=0, fetch_err=1. Variant with rvalid on the threshold cycle → data taken, fetch_err=0.
- mem_ready=0 for 5 cycles → mem_req=1 with mem_addr stable. Then Reset=0 while in WAIT → next cycle all outputs 0 and the late rvalid is ignored.
